// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream multiplexer: selection-mode encoding
// and the select/grant width helper.
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotate-priority search: finds the first requesting channel
// starting just after ptr_i and wrapping around. Holds no state.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = sel_width(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] gnt_o,
  output logic             any_o
);

  // Walk ptr+1, ptr+2, ... mod N_CH and latch the first request seen.
  always_comb begin
    logic [SEL_W-1:0] idx;
    gnt_o = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int off = 1; off <= N_CH; off++) begin
      idx = SEL_W'((int'(ptr_i) + off) % N_CH);
      if (!any_o && req_i[idx]) begin
        any_o = 1'b1;
        gnt_o = idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with a registered output stage. Selects one
// producer per cycle either from an external index (fixed mode) or by
// round-robin arbitration, and forwards its data into a single output slot.
//
// Handshake: a beat moves on a channel in the cycle where both its valid and
// ready are high. Producers must hold valid/data stable until accepted; the
// consumer takes the output beat when out_valid_o && out_ready_i. Ready never
// depends combinationally on any data bus.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int SEL_W = sel_width(N_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_CH*W-1:0] in_data_i,
  input  logic [N_CH-1:0]   in_valid_i,
  output logic [N_CH-1:0]   in_ready_o,
  input  logic              mode_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [W-1:0]      out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [SEL_W-1:0]  grant_o
);

  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] rr_gnt;
  logic             rr_any;
  logic             load_en;
  logic             sel_ok;
  logic [SEL_W-1:0] cand_idx;
  logic             cand_ok;
  logic             xfer;

  rr_arbiter #(
    .N_CH (N_CH),
    .SEL_W(SEL_W)
  ) u_arb (
    .req_i(in_valid_i),
    .ptr_i(ptr_q),
    .gnt_o(rr_gnt),
    .any_o(rr_any)
  );

  // Pick the candidate channel and drive the one-hot (or zero) ready vector.
  always_comb begin
    load_en    = !out_valid_q || out_ready_i;
    sel_ok     = int'(sel_i) < N_CH;
    cand_idx   = '0;
    cand_ok    = 1'b0;
    in_ready_o = '0;
    if (mode_e'(mode_i) == MODE_RR) begin
      cand_idx = rr_gnt;
      cand_ok  = rr_any;
    end else begin
      cand_idx = sel_i;
      cand_ok  = sel_ok;
    end
    for (int c = 0; c < N_CH; c++) begin
      in_ready_o[c] = load_en && cand_ok && (int'(cand_idx) == c);
    end
  end

  // Next-state for the output slot and the round-robin pointer.
  always_comb begin
    xfer        = cand_ok && load_en && in_valid_i[cand_idx];
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = in_data_i[int'(cand_idx)*W +: W];
      out_valid_d = 1'b1;
      grant_d     = cand_idx;
      ptr_d       = cand_idx;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; pointer resets to the last channel so channel 0 wins first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      ptr_q       <= SEL_W'(N_CH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign grant_o     = grant_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (N_CH=4, W=8) with an expected-beat queue.
module tb_stream_mux_rr;

  localparam int N_CH  = 4;
  localparam int W     = 8;
  localparam int SEL_W = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N_CH*W-1:0] in_data_i;
  logic [N_CH-1:0]   in_valid_i;
  logic [N_CH-1:0]   in_ready_o;
  logic              mode_i;
  logic [SEL_W-1:0]  sel_i;
  logic [W-1:0]      out_data_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [SEL_W-1:0]  grant_o;

  int checks   = 0;
  int failures = 0;

  logic [SEL_W+W-1:0] exp_q[$];
  logic [SEL_W+W-1:0] last_beat;

  stream_mux_rr #(.N_CH(N_CH), .W(W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .mode_i     (mode_i),
    .sel_i      (sel_i),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .grant_o    (grant_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_data();
    for (int c = 0; c < N_CH; c++) in_data_i[c*W +: W] = W'($urandom_range(0, 255));
  endtask

  // One cycle: check ready, record an expected beat if a handshake is due,
  // clock, then pop and compare the output slot.
  task automatic step(input string tag, input logic [N_CH-1:0] exp_rdy, input int exp_ch);
    logic [SEL_W+W-1:0] e;
    #1;
    chk({tag, "_ready"}, 32'(in_ready_o), 32'(exp_rdy));
    if (exp_ch >= 0) exp_q.push_back({SEL_W'(exp_ch), in_data_i[exp_ch*W +: W]});
    @(posedge clk_i);
    #1;
    if (exp_ch >= 0) begin
      e = exp_q.pop_front();
      last_beat = e;
      chk({tag, "_valid"}, 32'(out_valid_o), 32'd1);
      chk({tag, "_beat"}, 32'({grant_o, out_data_o}), 32'(e));
    end
  endtask

  initial begin
    // Reset
    rst_i       = 1'b1;
    in_data_i   = '0;
    in_valid_i  = '0;
    mode_i      = 1'b0;
    sel_i       = '0;
    out_ready_i = 1'b1;
    last_beat   = '0;
    #2;
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_data",  32'(out_data_o),  32'd0);
    chk("rst_grant", 32'(grant_o),     32'd0);
    chk("rst_ready", 32'(in_ready_o),  32'b0001);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Fixed mode, select channel 2
    sel_i      = 2'd2;
    in_data_i  = '0;
    in_data_i[2*W +: W] = 8'hA5;
    in_valid_i = 4'b0100;
    step("fixed_sel2", 4'b0100, 2);
    chk("fixed_sel2_data", 32'(out_data_o), 32'hA5);

    // Round-robin, all valid; pointer sits at 2 after the fixed transfer
    mode_i     = 1'b1;
    in_valid_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      int g;
      g = (3 + i) % N_CH;
      rand_data();
      step("rr_all", 4'(1 << g), g);
    end

    // Round-robin, only channels 1 and 3; pointer at 2 so 3 leads
    in_valid_i = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (i % 2 == 0) ? 3 : 1;
      rand_data();
      step("rr_odd", 4'(1 << g), g);
    end

    // Backpressure: slot full, consumer stalled for three cycles
    in_valid_i  = 4'b1111;
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step("stall", 4'b0000, -1);
      chk("stall_valid", 32'(out_valid_o), 32'd1);
      chk("stall_beat", 32'({grant_o, out_data_o}), 32'(last_beat));
    end
    // Release: drain and load channel 2 (pointer at 1) in the same cycle
    out_ready_i = 1'b1;
    step("release", 4'b0100, 2);

    // Fixed mode on an idle channel: ready shown, no transfer, slot drains
    mode_i     = 1'b0;
    sel_i      = 2'd1;
    in_valid_i = 4'b0001;
    rand_data();
    step("fixed_idle", 4'b0010, -1);
    chk("fixed_idle_valid", 32'(out_valid_o), 32'd0);
    chk("fixed_idle_hold", 32'({grant_o, out_data_o}), 32'(last_beat));
    // Switch to round-robin: channel 0 is the only requester
    mode_i = 1'b1;
    step("to_rr", 4'b0001, 0);

    // Asynchronous reset in the middle of a cycle with the slot full
    out_ready_i = 1'b0;
    #3;
    rst_i = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid_o), 32'd0);
    chk("async_rst_data",  32'(out_data_o),  32'd0);
    chk("async_rst_grant", 32'(grant_o),     32'd0);
    #1;
    rst_i       = 1'b0;
    out_ready_i = 1'b1;
    in_valid_i  = 4'b1111;
    rand_data();
    step("post_rst", 4'b0001, 0);
    step("post_rst2", 4'b0010, 1);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit stream multiplexer with a registered output stage, valid/ready handshakes on every channel, and two selection modes: fixed (external select) and round-robin arbitration. It succeeds the team's single-bit combinational muxes and sits between multiple producer streams and one consumer wherever channels share a datapath.

## Interface
Parameters:
- N_CH, 4, number of input channels (≥2)
- W, 8, data width per channel
- SEL_W, $clog2(N_CH), derived select/grant width

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- in_data_i  input  N_CH*W  channel c occupies bits [c*W +: W]
- in_valid_i  input  N_CH  per-channel valid
- in_ready_o  output  N_CH  per-channel ready (one-hot or zero)
- mode_i  input  1  0 = fixed select, 1 = round-robin
- sel_i  input  SEL_W  channel index used in fixed mode
- out_data_o  output  W  registered output data
- out_valid_o  output  1  output register holds data
- out_ready_i  input  1  consumer ready
- grant_o  output  SEL_W  index of channel whose data is in the output register

## Operation
- load_en = !out_valid_o || out_ready_i (register empty or being drained this cycle).
- Candidate channel g: fixed mode → g = sel_i; round-robin → first c with in_valid_i[c] set, searching ptr+1, ptr+2, … mod N_CH.
- in_ready_o[g] = load_en && candidate exists; all other bits 0. Fixed mode: in_ready_o[sel_i] = load_en regardless of in_valid_i[sel_i].
- Transfer on in_valid_i[g] && in_ready_o[g]: out_data_o ← channel g data, grant_o ← g, out_valid_o ← 1.
- Drain without new transfer (out_ready_i && out_valid_o, no input transfer): out_valid_o ← 0; out_data_o and grant_o hold.
- Round-robin pointer ptr updates to g only on a transfer; fixed-mode transfers also update ptr (fairness restarts after the last served channel).
- sel_i ≥ N_CH (non-power-of-two N_CH): no channel ready, no transfer.
- mode_i and sel_i sampled combinationally each cycle; a change affects only the next load decision, never data already registered.
- Out-of-range or non-candidate channels never see ready; their data is ignored.

## Timing
- Reset values: out_valid_o 0, out_data_o 0, grant_o 0, ptr N_CH-1 (channel 0 first priority); in_ready_o follows combinationally (all-ones-capable bit at candidate after reset since load_en=1).
- Latency: input handshake at cycle t → out_valid_o high at t+1.
- Throughput: one transfer per cycle when out_ready_i held high (simultaneous drain and load in the same cycle).
- Backpressure: while out_valid_o && !out_ready_i, out_data_o/grant_o stable and all in_ready_o = 0.
- Reset asserted mid-stream: outputs and ptr return to reset values immediately (asynchronous); pending output data is discarded.
- in_ready_o depends combinationally on out_ready_i, mode_i, sel_i, in_valid_i (round-robin) — no combinational path from in_data_i.

## Structure
- Shared package stream_mux_pkg: mode encoding constants MODE_FIXED = 1'b0, MODE_RR = 1'b1 as an enum typedef; width helper for SEL_W.
- Sub-module rr_arbiter (parameter N_CH): combinational rotate-priority search given req vector and ptr, outputs gnt index and any-grant flag; pointer register stays in stream_mux_rr.

## Test plan
- Reset then fixed mode, sel_i=2, ch2 data 0xA5 valid, out_ready_i=1 → in_ready_o=4'b0100, next cycle out_data_o=0xA5, grant_o=2, out_valid_o=1.
- Round-robin, all four channels valid continuously, out_ready_i=1 → grant_o sequence 0,1,2,3,0,… one per cycle.
- Round-robin, only ch1 and ch3 valid → grants alternate 1,3,1,3; ch0/ch2 in_ready_o never asserted.
- Output full, out_ready_i=0 for 3 cycles → out_data_o/grant_o unchanged, in_ready_o=0; release → drain and new load in same cycle.
- Fixed mode sel_i=1 with ch1 invalid, ch0 valid → no transfer, out_valid_o falls after drain; switch mode_i=1 → ch0 granted next cycle.
- Assert rst_i mid-transfer with out_valid_o=1 → out_valid_o=0, out_data_o=0, grant_o=0 without a clock edge; after release channel 0 wins first.
